// File: rtl/axis_sink_pkt_fifo.sv
// AXI4-Stream sink with an on-chip circular FIFO and a first-word-fall-through read port.
// It carries TKEEP/TLAST, reports fill and packet counts, and can optionally hold reads until a whole packet is stored.
module axis_sink_pkt_fifo #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int ALMOST_FULL_THRESH   = 12,
  parameter int PACKET_MODE          = 0
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESETN,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  input  logic                                rd_en,
  output logic                                rd_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     rd_data,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   rd_keep,
  output logic                                rd_last,
  output logic [$clog2(FIFO_DEPTH):0]         fill_level,
  output logic [$clog2(FIFO_DEPTH):0]         pkt_count,
  output logic                                almost_full,
  output logic                                rd_err,
  input  logic                                err_clr
);
  localparam int KW = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = C_S_AXIS_TDATA_WIDTH + KW + 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(ALMOST_FULL_THRESH);

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d, pkt_q, pkt_d;
  logic          tready_q, tready_d;
  logic          rd_err_q, rd_err_d;
  logic          fallback_q, fallback_d;
  logic          full, push, pop, pkt_inc, pkt_dec;
  logic [EW-1:0] head;

  // Handshakes: a source word moves when S_AXIS_TVALID && S_AXIS_TREADY at a rising edge;
  // a head word leaves when rd_en && rd_valid. TVALID without TREADY leaves no state behind.
  always_comb begin
    full    = (fill_q == FULL_LVL);
    push    = S_AXIS_TVALID & tready_q;
    head    = mem_q[rd_ptr_q];
    if (PACKET_MODE == 0) begin
      rd_valid = (fill_q != '0);
    end else begin
      // Oversize packets that can never complete inside the buffer drain cut-through.
      rd_valid = (pkt_q != '0) | (full & (pkt_q == '0)) | fallback_q;
    end
    pop     = rd_en & rd_valid;
    pkt_inc = push & S_AXIS_TLAST;
    pkt_dec = pop & head[EW-1];

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    pkt_d = pkt_q;
    case ({pkt_inc, pkt_dec})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase

    tready_d = (fill_d != FULL_LVL);

    rd_err_d = rd_err_q;
    if (rd_en && !rd_valid) rd_err_d = 1'b1;
    else if (err_clr)       rd_err_d = 1'b0;

    fallback_d = fallback_q;
    if (pkt_dec)                    fallback_d = 1'b0;
    else if (full && pkt_q == '0)   fallback_d = 1'b1;
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      pkt_q      <= '0;
      tready_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      pkt_q      <= pkt_d;
      tready_q   <= tready_d;
      rd_err_q   <= rd_err_d;
      fallback_q <= fallback_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA};
  end

  assign S_AXIS_TREADY = tready_q;
  assign rd_data       = head[C_S_AXIS_TDATA_WIDTH-1:0];
  assign rd_keep       = head[C_S_AXIS_TDATA_WIDTH +: KW];
  assign rd_last       = head[EW-1];
  assign fill_level    = fill_q;
  assign pkt_count     = pkt_q;
  assign almost_full   = (fill_q >= AF_LVL);
  assign rd_err        = rd_err_q;
endmodule

// File: tb/tb_axis_sink_pkt_fifo.sv
// Directed bench for axis_sink_pkt_fifo: a cut-through instance (a_*) and a store-and-forward instance (b_*).
module tb_axis_sink_pkt_fifo;
  localparam int W  = 32;
  localparam int KW = 4;
  localparam int EW = W + KW + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_tready, a_tlast, a_tvalid, a_rd_en, a_rd_valid, a_rd_last, a_af, a_err, a_clr;
  logic [W-1:0]  a_tdata, a_rd_data;
  logic [KW-1:0] a_tkeep, a_rd_keep;
  logic [4:0]    a_fill, a_pkt;
  logic          b_tready, b_tlast, b_tvalid, b_rd_en, b_rd_valid, b_rd_last, b_af, b_err, b_clr;
  logic [W-1:0]  b_tdata, b_rd_data;
  logic [KW-1:0] b_tkeep, b_rd_keep;
  logic [4:0]    b_fill, b_pkt;

  axis_sink_pkt_fifo #(.PACKET_MODE(0)) dut_a (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TREADY(a_tready),
    .S_AXIS_TDATA(a_tdata), .S_AXIS_TKEEP(a_tkeep), .S_AXIS_TLAST(a_tlast),
    .S_AXIS_TVALID(a_tvalid), .rd_en(a_rd_en), .rd_valid(a_rd_valid),
    .rd_data(a_rd_data), .rd_keep(a_rd_keep), .rd_last(a_rd_last),
    .fill_level(a_fill), .pkt_count(a_pkt), .almost_full(a_af),
    .rd_err(a_err), .err_clr(a_clr)
  );

  axis_sink_pkt_fifo #(.PACKET_MODE(1)) dut_b (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TREADY(b_tready),
    .S_AXIS_TDATA(b_tdata), .S_AXIS_TKEEP(b_tkeep), .S_AXIS_TLAST(b_tlast),
    .S_AXIS_TVALID(b_tvalid), .rd_en(b_rd_en), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .rd_keep(b_rd_keep), .rd_last(b_rd_last),
    .fill_level(b_fill), .pkt_count(b_pkt), .almost_full(b_af),
    .rd_err(b_err), .err_clr(b_clr)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int nv, acc, pops, sent;
  logic took;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_tlast, a_tvalid, a_rd_en, a_clr, a_tdata, a_tkeep} = '0;
    {b_tlast, b_tvalid, b_rd_en, b_clr, b_tdata, b_tkeep} = '0;
    step(); step();
    check("rst_tready", a_tready, 0);
    check("rst_rd_valid", a_rd_valid, 0);
    check("rst_fill", a_fill, 0);
    check("rst_af", a_af, 0);
    check("rst_err", a_err, 0);
    check("rst_b_tready", b_tready, 0);
    rst_n = 1'b1;
    step();
    check("tready_release", a_tready, 1);

    // Fill: 20 offered words, only 16 fit.
    nv = 0; acc = 0;
    for (int c = 0; c < 20; c++) begin
      a_tvalid = 1'b1; a_tdata = 32'(nv); a_tkeep = 4'hF; a_tlast = (nv == 3 || nv == 7);
      check("fill_tready", a_tready, acc < 16);
      took = (acc < 16);
      step();
      if (took) begin
        exp_q.push_back({a_tlast, a_tkeep, a_tdata});
        nv++; acc++;
      end
      check("fill_level", a_fill, acc);
      check("fill_af", a_af, acc >= 12);
    end
    check("full_pkt", a_pkt, 2);
    check("full_tready", a_tready, 0);

    // One pop while full; TREADY comes back a cycle later and 0x10 lands.
    check("pop_valid", a_rd_valid, 1);
    check("pop_head", a_rd_data, 0);
    a_rd_en = 1'b1;
    step();
    a_rd_en = 1'b0;
    void'(exp_q.pop_front());
    check("pop_fill", a_fill, 15);
    check("pop_tready_back", a_tready, 1);
    step();
    exp_q.push_back({1'b0, 4'hF, 32'h10});
    a_tvalid = 1'b0;
    check("refill_fill", a_fill, 16);
    check("refill_tready", a_tready, 0);

    for (int i = 0; i < 16; i++) begin
      exp_e = exp_q.pop_front();
      check("drain_valid", a_rd_valid, 1);
      check("drain_entry", {a_rd_last, a_rd_keep, a_rd_data}, exp_e);
      check("drain_data_seq", a_rd_data, i + 1);
      a_rd_en = 1'b1;
      step();
    end
    a_rd_en = 1'b0;
    check("drain_fill", a_fill, 0);
    check("drain_valid_low", a_rd_valid, 0);
    check("drain_pkt", a_pkt, 0);
    check("drain_af", a_af, 0);

    // Read of an empty FIFO, error clear, and clear-vs-error priority.
    a_rd_en = 1'b1; step(); a_rd_en = 1'b0;
    check("err_set", a_err, 1);
    check("err_fill", a_fill, 0);
    a_clr = 1'b1; step(); a_clr = 1'b0;
    check("err_clr", a_err, 0);
    a_rd_en = 1'b1; a_clr = 1'b1; step(); a_rd_en = 1'b0; a_clr = 1'b0;
    check("err_wins", a_err, 1);
    a_clr = 1'b1; step(); a_clr = 1'b0;
    check("err_clr2", a_err, 0);

    // Streaming: push and pop every cycle, fill stays at 1.
    nv = 32'h100;
    for (int c = 0; c < 100; c++) begin
      a_tvalid = 1'b1; a_tdata = 32'(nv); a_tkeep = nv[3:0]; a_tlast = nv[1];
      a_rd_en = (c > 0);
      check("stream_valid", a_rd_valid, c > 0);
      if (c > 0) check("stream_entry", {a_rd_last, a_rd_keep, a_rd_data}, exp_q[0]);
      step();
      exp_q.push_back({a_tlast, a_tkeep, a_tdata});
      nv++;
      if (c > 0) void'(exp_q.pop_front());
      check("stream_fill", a_fill, 1);
    end
    a_tvalid = 1'b0;
    check("stream_tail", {a_rd_last, a_rd_keep, a_rd_data}, exp_q[0]);
    void'(exp_q.pop_front());
    step();
    a_rd_en = 1'b0;
    check("stream_end_fill", a_fill, 0);
    check("stream_no_err", a_err, 0);

    // Store-and-forward: reads held until TLAST is stored.
    b_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_tvalid = 1'b1; b_tdata = 32'hA0 + 32'(i); b_tkeep = 4'hF; b_tlast = (i == 2);
      check("pm_hold", b_rd_valid, 0);
      step();
    end
    b_tvalid = 1'b0;
    check("pm_ready_valid", b_rd_valid, 1);
    check("pm_pkt1", b_pkt, 1);
    for (int i = 0; i < 3; i++) begin
      check("pm_pop_valid", b_rd_valid, 1);
      check("pm_pop_data", b_rd_data, 32'hA0 + 32'(i));
      check("pm_pop_last", b_rd_last, i == 2);
      step();
    end
    b_rd_en = 1'b0;
    check("pm_pkt0", b_pkt, 0);
    check("pm_valid_low", b_rd_valid, 0);
    check("pm_fill0", b_fill, 0);
    b_clr = 1'b1; step(); b_clr = 1'b0;
    check("pm_err_clr", b_err, 0);

    // Oversize packet: 20 words into 16 entries drains by fallback.
    nv = 32'h200;
    for (int c = 0; c < 16; c++) begin
      b_tvalid = 1'b1; b_tdata = 32'(nv); b_tkeep = 4'hF; b_tlast = 1'b0;
      check("big_wait", b_rd_valid, 0);
      step();
      nv++;
    end
    check("big_fill", b_fill, 16);
    check("big_pkt0", b_pkt, 0);
    check("big_fallback", b_rd_valid, 1);
    sent = 16; pops = 0;
    for (int c = 0; c < 100 && pops < 20; c++) begin
      b_tvalid = (sent < 20); b_tdata = 32'h200 + 32'(sent); b_tlast = (sent == 19);
      b_rd_en = 1'b1;
      check("big_valid", b_rd_valid, 1);
      check("big_data", b_rd_data, 32'h200 + 32'(pops));
      check("big_last", b_rd_last, pops == 19);
      took = b_tready & b_tvalid;
      step();
      if (took) sent++;
      pops++;
    end
    b_rd_en = 1'b0; b_tvalid = 1'b0;
    check("big_pops", pops, 20);
    check("big_valid_low", b_rd_valid, 0);
    check("big_fill0", b_fill, 0);
    check("big_pkt_end", b_pkt, 0);

    // Asynchronous reset in the middle of a packet.
    a_tvalid = 1'b1; a_tlast = 1'b0; a_tdata = 32'h55;
    step(); step();
    a_tvalid = 1'b0;
    check("mid_fill", a_fill, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tready", a_tready, 0);
    check("arst_fill", a_fill, 0);
    check("arst_valid", a_rd_valid, 0);
    check("arst_b_tready", b_tready, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_tready", a_tready, 1);
    check("post_rst_valid", a_rd_valid, 0);
    check("post_rst_fill", a_fill, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
